// File: rtl/watchdog_supervisor.sv
// Watchdog supervisor: runs a timeout window that every requester selected in
// req_mask must check in to once per window. Simultaneous kicks are serialized
// by a round-robin arbiter. A missed window raises warn_irq and opens a grace
// window; a missed grace window drives sys_rst_req for RST_PULSE cycles.
//
// Ports:
//   clk, reset    system clock, synchronous active-high reset
//   en            enable; arming happens on its rising edge while IDLE
//   req_mask      requesters that must check in each window
//   kick          per-requester kick, held high until acknowledged
//   kick_ack      one-hot grant, one cycle; check-in recorded that cycle
//   warn_irq      one-cycle pulse in the cycle the timeout window expires
//   sys_rst_req   high while in RESET_REQ (RST_PULSE cycles)
//   missing       req_mask & ~checkin, captured on WARN entry
//   expire_count  saturating count of WARN entries
//   state         0=IDLE 1=ARMED 2=WARN 3=RESET_REQ
module watchdog_supervisor #(
  parameter int unsigned NREQ           = 4,
  parameter int unsigned TIMEOUT_CYCLES = 150000,
  parameter int unsigned GRACE_CYCLES   = 50000,
  parameter int unsigned RST_PULSE      = 16,
  parameter int unsigned CW             = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic [NREQ-1:0] req_mask,
  input  logic [NREQ-1:0] kick,
  output logic [NREQ-1:0] kick_ack,
  output logic            warn_irq,
  output logic            sys_rst_req,
  output logic [NREQ-1:0] missing,
  output logic [7:0]      expire_count,
  output logic [1:0]      state
);

  localparam int unsigned   RRW        = $clog2(NREQ);
  localparam logic [CW-1:0] TC_TIMEOUT = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] TC_GRACE   = CW'(GRACE_CYCLES - 1);
  localparam logic [CW-1:0] TC_PULSE   = CW'(RST_PULSE - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARMED     = 2'd1,
    WARN      = 2'd2,
    RESET_REQ = 2'd3
  } state_t;

  state_t          st, st_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic [NREQ-1:0] checkin, checkin_nx;
  logic [NREQ-1:0] missing_nx;
  logic [NREQ-1:0] grant;
  logic [NREQ-1:0] have;
  logic [RRW-1:0]  rr, rr_nx, grant_idx;
  logic [7:0]      expire_nx;
  logic            en_q;
  logic            found;
  logic            complete;

  // Round-robin search from rr+1: first scan indices above rr, then wrap to
  // indices at or below rr. Equivalent to a modulo walk without a divider.
  always_comb begin
    grant     = '0;
    grant_idx = rr;
    found     = 1'b0;
    if (st == ARMED || st == WARN) begin
      for (int unsigned j = 0; j < NREQ; j++) begin
        if (!found && kick[j] && (j > 32'(rr))) begin
          found     = 1'b1;
          grant[j]  = 1'b1;
          grant_idx = RRW'(j);
        end
      end
      for (int unsigned j = 0; j < NREQ; j++) begin
        if (!found && kick[j] && (j <= 32'(rr))) begin
          found     = 1'b1;
          grant[j]  = 1'b1;
          grant_idx = RRW'(j);
        end
      end
    end
  end

  always_comb begin
    st_nx      = st;
    cnt_nx     = cnt;
    checkin_nx = checkin;
    missing_nx = missing;
    expire_nx  = expire_count;
    rr_nx      = found ? grant_idx : rr;
    warn_irq   = 1'b0;
    // The grant of this cycle counts toward completion immediately, so a
    // check-in on the terminal count beats expiry.
    have       = checkin | (grant & req_mask);
    complete   = ((have & req_mask) == req_mask);

    unique case (st)
      IDLE: begin
        if (en && !en_q) begin
          st_nx      = ARMED;
          cnt_nx     = '0;
          checkin_nx = '0;
        end
      end
      ARMED, WARN: begin
        if (!en) begin
          st_nx      = IDLE;
          cnt_nx     = '0;
          checkin_nx = '0;
        end else if (complete) begin
          st_nx      = ARMED;
          cnt_nx     = '0;
          checkin_nx = '0;
          if (st == WARN) missing_nx = '0;
        end else if (cnt == ((st == ARMED) ? TC_TIMEOUT : TC_GRACE)) begin
          cnt_nx     = '0;
          checkin_nx = have;
          if (st == ARMED) begin
            st_nx      = WARN;
            warn_irq   = 1'b1;
            missing_nx = req_mask & ~have;
            if (expire_count != 8'hFF) expire_nx = expire_count + 8'd1;
          end else begin
            st_nx = RESET_REQ;
          end
        end else begin
          cnt_nx     = cnt + CW'(1);
          checkin_nx = have;
        end
      end
      RESET_REQ: begin
        if (cnt == TC_PULSE) begin
          st_nx      = IDLE;
          cnt_nx     = '0;
          checkin_nx = '0;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      default: st_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st           <= IDLE;
      cnt          <= '0;
      checkin      <= '0;
      rr           <= '0;
      en_q         <= 1'b0;
      missing      <= '0;
      expire_count <= '0;
    end else begin
      st           <= st_nx;
      cnt          <= cnt_nx;
      checkin      <= checkin_nx;
      rr           <= rr_nx;
      en_q         <= en;
      missing      <= missing_nx;
      expire_count <= expire_nx;
    end
  end

  assign kick_ack    = grant;
  assign sys_rst_req = (st == RESET_REQ);
  assign state       = st;

endmodule

// File: tb/tb_watchdog_supervisor.sv
// Testbench for watchdog_supervisor. A driver issues directed scenarios and
// random traffic, runs a behavioural reference model and queues the expected
// outputs for every cycle; a monitor pops and compares them at the falling edge.
module tb_watchdog_supervisor;
  localparam int NREQ = 4;
  localparam int TMO  = 10;
  localparam int GRC  = 5;
  localparam int RSTP = 3;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            en = 1'b0;
  logic [NREQ-1:0] req_mask = '0;
  logic [NREQ-1:0] kick = '0;
  logic [NREQ-1:0] kick_ack;
  logic            warn_irq;
  logic            sys_rst_req;
  logic [NREQ-1:0] missing;
  logic [7:0]      expire_count;
  logic [1:0]      state;

  watchdog_supervisor #(
    .NREQ(NREQ),
    .TIMEOUT_CYCLES(TMO),
    .GRACE_CYCLES(GRC),
    .RST_PULSE(RSTP),
    .CW(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .en(en),
    .req_mask(req_mask),
    .kick(kick),
    .kick_ack(kick_ack),
    .warn_irq(warn_irq),
    .sys_rst_req(sys_rst_req),
    .missing(missing),
    .expire_count(expire_count),
    .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NREQ-1:0] ack;
    logic            warn;
    logic            rst;
    logic [NREQ-1:0] miss;
    logic [7:0]      ec;
    logic [1:0]      st;
    int              cyc;
  } exp_t;

  exp_t sbq[$];
  int total = 0;
  int bad = 0;
  int ncyc = 0;

  // reference model state: mode 0 idle, 1 armed, 2 warn, 3 reset request
  int        m_mode, m_cnt, m_rr, m_exp;
  bit [3:0]  m_chk, m_miss;
  bit        m_enq;

  bit [3:0]  pend;
  bit        en_v;
  bit [3:0]  mask_v;
  logic [3:0] ack_obs;
  logic      warn_obs;

  task automatic chk(input string name, input int cyc, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, got, want);
    end
  endtask

  task automatic model_clear();
    m_mode = 0; m_cnt = 0; m_rr = 0; m_exp = 0;
    m_chk = '0; m_miss = '0; m_enq = 1'b0;
  endtask

  task automatic model_step(input bit r, input bit e, input bit [3:0] m, input bit [3:0] k, output exp_t o);
    int g, lim, c;
    bit [3:0] have;
    bit done;
    o.st = 2'(m_mode);
    o.miss = m_miss;
    o.ec = 8'(m_exp);
    o.rst = (m_mode == 3);
    o.ack = '0;
    o.warn = 1'b0;
    o.cyc = 0;
    g = -1;
    if (m_mode == 1 || m_mode == 2)
      for (int off = 1; off <= NREQ; off++) begin
        c = (m_rr + off) % NREQ;
        if (g < 0 && k[c]) g = c;
      end
    if (g >= 0) o.ack[g] = 1'b1;
    have = m_chk | (o.ack & m);
    done = ((have & m) == m);
    lim = (m_mode == 1) ? TMO : GRC;
    if (m_mode == 1 && e && !done && m_cnt == lim - 1) o.warn = 1'b1;
    if (r) begin
      model_clear();
    end else begin
      if (g >= 0) m_rr = g;
      case (m_mode)
        0: if (e && !m_enq) begin m_mode = 1; m_cnt = 0; m_chk = '0; end
        1, 2: begin
          if (!e) begin
            m_mode = 0; m_cnt = 0; m_chk = '0;
          end else if (done) begin
            if (m_mode == 2) m_miss = '0;
            m_mode = 1; m_cnt = 0; m_chk = '0;
          end else if (m_cnt == lim - 1) begin
            if (m_mode == 1) begin
              m_mode = 2;
              m_miss = m & ~have;
              if (m_exp < 255) m_exp++;
            end else begin
              m_mode = 3;
            end
            m_cnt = 0; m_chk = have;
          end else begin
            m_cnt++; m_chk = have;
          end
        end
        default: begin
          if (m_cnt == RSTP - 1) begin m_mode = 0; m_cnt = 0; m_chk = '0; end
          else m_cnt++;
        end
      endcase
      m_enq = e;
    end
  endtask

  // entered and left at posedge+1
  task automatic cycle(input bit r);
    exp_t e;
    reset = r; en = en_v; req_mask = mask_v; kick = pend;
    model_step(r, en_v, mask_v, pend, e);
    e.cyc = ncyc;
    ncyc++;
    sbq.push_back(e);
    #2;
    ack_obs = kick_ack;
    warn_obs = warn_irq;
    @(posedge clk);
    #1;
    pend = pend & ~e.ack;
  endtask

  task automatic do_reset();
    pend = '0; en_v = 1'b0;
    cycle(1'b1);
  endtask

  task automatic arm();
    en_v = 1'b0; cycle(1'b0);
    en_v = 1'b1; cycle(1'b0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        chk("kick_ack", e.cyc, 32'(kick_ack), 32'(e.ack));
        chk("warn_irq", e.cyc, 32'(warn_irq), 32'(e.warn));
        chk("sys_rst_req", e.cyc, 32'(sys_rst_req), 32'(e.rst));
        chk("missing", e.cyc, 32'(missing), 32'(e.miss));
        chk("expire_count", e.cyc, 32'(expire_count), 32'(e.ec));
        chk("state", e.cyc, 32'(state), 32'(e.st));
      end
    end
  end

  initial begin : watchdog_timer
    #2000000;
    $display("FAIL sim_timeout cyc=%0d got=running want=finished", ncyc);
    $fatal(1);
  end

  initial begin : driver
    logic [3:0] seq [4];
    int nr;
    pend = '0; en_v = 1'b0; mask_v = '0;
    @(posedge clk);
    #1;
    model_clear();

    // basic check-in
    do_reset();
    mask_v = 4'b0011;
    arm();
    repeat (100) begin
      if (m_mode == 1 && m_cnt == 2) pend[0] = 1'b1;
      if (m_mode == 1 && m_cnt == 5) pend[1] = 1'b1;
      cycle(1'b0);
    end
    chk("basic_state", ncyc, 32'(state), 32'd1);
    chk("basic_expire", ncyc, 32'(expire_count), 32'd0);

    // round-robin contention
    do_reset();
    mask_v = 4'b1111;
    arm();
    pend = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0);
      seq[i] = ack_obs;
    end
    chk("rr_grant0", ncyc, 32'(seq[0]), 32'b0010);
    chk("rr_grant1", ncyc, 32'(seq[1]), 32'b0100);
    chk("rr_grant2", ncyc, 32'(seq[2]), 32'b1000);
    chk("rr_grant3", ncyc, 32'(seq[3]), 32'b0001);

    // warning then recovery
    do_reset();
    mask_v = 4'b0011;
    arm();
    for (int i = 0; i < 30 && m_mode != 2; i++) begin
      if (m_mode == 1 && m_cnt == 2) pend[0] = 1'b1;
      cycle(1'b0);
    end
    chk("warn_state", ncyc, 32'(state), 32'd2);
    chk("warn_missing", ncyc, 32'(missing), 32'b0010);
    chk("warn_expire", ncyc, 32'(expire_count), 32'd1);
    pend[1] = 1'b1;
    cycle(1'b0);
    chk("recover_state", ncyc, 32'(state), 32'd1);
    chk("recover_missing", ncyc, 32'(missing), 32'd0);

    // full escalation, en held high
    for (int i = 0; i < 40 && m_mode != 3; i++) cycle(1'b0);
    nr = int'(sys_rst_req);
    repeat (6) begin
      cycle(1'b0);
      nr += int'(sys_rst_req);
    end
    chk("rst_pulse_len", ncyc, 32'(nr), 32'd3);
    chk("held_en_idle", ncyc, 32'(state), 32'd0);
    en_v = 1'b0; cycle(1'b0);
    en_v = 1'b1; cycle(1'b0);
    chk("rearm_state", ncyc, 32'(state), 32'd1);

    // terminal-count race
    do_reset();
    mask_v = 4'b0011;
    arm();
    for (int i = 0; i < 10; i++) begin
      if (i == 2) pend[0] = 1'b1;
      if (i == 9) pend[1] = 1'b1;
      cycle(1'b0);
    end
    chk("race_warn", ncyc, 32'(warn_obs), 32'd0);
    chk("race_state", ncyc, 32'(state), 32'd1);
    repeat (9) cycle(1'b0);
    chk("race_restart_armed", ncyc, 32'(state), 32'd1);
    cycle(1'b0);
    chk("race_restart_warn", ncyc, 32'(state), 32'd2);

    // disable while in WARN
    en_v = 1'b0;
    cycle(1'b0);
    chk("disable_idle", ncyc, 32'(state), 32'd0);
    chk("disable_missing_held", ncyc, 32'(missing), 32'b0011);

    // reset while in RESET_REQ
    en_v = 1'b1;
    cycle(1'b0);
    for (int i = 0; i < 40 && m_mode != 3; i++) cycle(1'b0);
    chk("rstreq_entered", ncyc, 32'(sys_rst_req), 32'd1);
    cycle(1'b1);
    chk("rstreq_reset_pulse", ncyc, 32'(sys_rst_req), 32'd0);
    chk("rstreq_reset_expire", ncyc, 32'(expire_count), 32'd0);

    // random traffic
    en_v = 1'b1;
    mask_v = 4'b0011;
    for (int i = 0; i < 3000; i++) begin
      if (en_v ? ($urandom_range(0, 99) < 2) : ($urandom_range(0, 99) < 15)) en_v = ~en_v;
      if ($urandom_range(0, 99) < 2) mask_v = 4'($urandom_range(0, 15));
      for (int q = 0; q < NREQ; q++)
        if ($urandom_range(0, 99) < 9) pend[q] = 1'b1;
      cycle($urandom_range(0, 299) == 0);
    end

    repeat (2) @(negedge clk);
    chk("scoreboard_drain", ncyc, 32'(sbq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/watchdog_supervisor.md
Name: watchdog_supervisor

Overview:
Sequences a watchdog timeout window shared by NREQ software or hardware tasks. All tasks selected in the required mask must check in once per window. Simultaneous check-ins are serialized by a round-robin arbiter. A missed window escalates in two steps: first a warning interrupt and grace window, then a system reset request pulse. The block sits between task kick sources and the SoC reset controller and interrupt controller.

Parameters:
NREQ, 4, number of kick requesters (2..16)
TIMEOUT_CYCLES, 150000, window length in clk cycles (3000us at 20ns)
GRACE_CYCLES, 50000, grace window length after warning, in clk cycles
RST_PULSE, 16, sys_rst_req high time in cycles (>=1)
CW, 32, width of internal window counter; must hold max(TIMEOUT_CYCLES, GRACE_CYCLES)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
en  input  1  supervisor enable; arming occurs on a rising edge of en
req_mask  input  NREQ  requesters that must check in each window; sampled every cycle
kick  input  NREQ  per-requester kick request; a requester holds it high until kick_ack
kick_ack  output  NREQ  one-hot grant, high for 1 cycle; the check-in is recorded that cycle
warn_irq  output  1  1-cycle pulse on entry to WARN
sys_rst_req  output  1  high for RST_PULSE cycles in RESET_REQ
missing  output  NREQ  req_mask & ~checkin, latched on WARN entry
expire_count  output  8  saturating count of WARN entries
state  output  2  0=IDLE, 1=ARMED, 2=WARN, 3=RESET_REQ

Behaviour:
- Reset (synchronous, high) forces the following, all on the next clk edge:
  - state=IDLE
  - counter=0
  - checkin=0
  - rr pointer=0
  - en_q=0
  - all outputs 0
- expire_count is cleared only by reset.
- IDLE:
  - No grants are issued.
  - On en & ~en_q, go to ARMED with counter=0 and checkin=0.
- Arbiter (ARMED and WARN only):
  - At most one grant per cycle.
  - Search starts at index rr+1 modulo NREQ.
  - After a grant, rr is set to the granted index.
  - Kicks from requesters not in req_mask are still granted, but set no checkin bit.
  - A kick from a requester whose checkin bit is already set is granted and has no other effect.
- Completion: (checkin | granted bit this cycle) & req_mask == req_mask.
  - On completion, counter=0 and checkin=0 next cycle.
  - If in WARN, go to ARMED and clear missing.
  - If req_mask==0, completion is true every cycle: the counter stays 0 and expiry never occurs.
- ARMED:
  - counter increments each cycle.
  - If counter==TIMEOUT_CYCLES-1 and there is no completion that cycle, go to WARN:
    - warn_irq=1 for that one cycle
    - missing latched
    - expire_count increments, saturating at 255
    - counter=0
    - checkin kept
- Completion in the terminal-count cycle wins over expiry.
- WARN:
  - The counter runs against GRACE_CYCLES-1.
  - Completion returns to ARMED.
  - Grace expiry with no completion goes to RESET_REQ with counter=0.
- RESET_REQ:
  - sys_rst_req=1 for exactly RST_PULSE cycles.
  - No grants are issued.
  - Then go to IDLE with checkin=0.
  - en is ignored until the pulse is complete.
  - Re-arming needs a fresh en rising edge after returning to IDLE.
- en=0 in ARMED or WARN goes to IDLE on the next cycle and clears counter and checkin; missing holds.
- en_q registers en every cycle, in all states.
- req_mask changes take effect in the same cycle's completion evaluation.
- A counter wrap past 2^CW is impossible by construction; the comparison uses the full CW bits.

Test Plan:
(Bench params: NREQ=4, TIMEOUT=10, GRACE=5, RST_PULSE=3.)
- Basic check-in:
  - Stimulus: reset, en rises, mask=4'b0011; kick[0] at cycle 2 and kick[1] at cycle 5 of each window.
  - Required: state stays ARMED for 100 cycles; warn_irq never pulses; each kick_ack is 1 cycle.
- Round-robin contention:
  - Stimulus: kick=4'b1111 held; each requester drops its kick after its ack.
  - Required: kick_ack sequence 0010, 0100, 1000, 0001 (rr starts at 0), one grant per cycle.
- Warning then recovery:
  - Stimulus: mask=0011; only kick[0] is supplied.
  - Required: warn_irq pulses at window cycle 9; missing=0010; expire_count=1; state=2.
  - Then kick[1] in grace gives state=1 and missing=0.
- Full escalation:
  - Stimulus: no kicks.
  - Required: WARN at cycle 9, RESET_REQ after 5 more cycles, sys_rst_req high exactly 3 cycles, then IDLE.
  - A held en does not re-arm; en toggled 0 then 1 re-arms.
- Terminal-count race:
  - Stimulus: the final required kick is granted on counter==9.
  - Required: no warn_irq; counter=0 next cycle.
- Disable and reset mid-operation:
  - Stimulus: en=0 while in WARN.
  - Required: IDLE next cycle.
  - Stimulus: reset asserted during RESET_REQ.
  - Required: sys_rst_req=0 and expire_count=0 next cycle.
